sort_pkt_tx: RTL
================

// Module: sort_pkt_tx
// PURPOSE
//  Avalon-ST packet transmitter: loads one packet of DWIDTH words over a simple load port into
//  on-chip RAM, then replays it on an Avalon-ST source (sop/eop/valid/ready).
//  Feeds the sort block's snk_* port and is the stimulus source in sort-block benches.
//  One packet in flight: load, send, return to load.
// PARAMETERS
//  DWIDTH       8     data word width, bits
//  MAX_PKT_LEN  1024  max words per packet; power of two, >= 2; AWIDTH = $clog2(MAX_PKT_LEN)
// PORTS
//  clk_i                input   1       single clock, all logic on posedge
//  srst_i               input   1       reset, synchronous, active-high
//  load_data_i          input   DWIDTH  word to store
//  load_valid_i         input   1       load_data_i valid
//  load_last_i          input   1       final word of packet (qualified by load_valid_i)
//  load_ready_o         output  1       block accepts load words
//  src_data_o           output  DWIDTH  Avalon-ST data
//  src_startofpacket_o  output  1       first beat of packet
//  src_endofpacket_o    output  1       last beat of packet
//  src_valid_o          output  1       beat valid
//  src_ready_i          input   1       downstream ready, ready latency 0
//  busy_o               output  1       high from accepted load_last until final beat accepted
// BEHAVIOUR
//  Clocking/reset: one clock clk_i; srst_i synchronous, active-high.
//  Reset values: load_ready_o=1, src_valid_o=0, src_startofpacket_o=0, src_endofpacket_o=0,
//   busy_o=0, src_data_o=0. State=LOAD, write/read pointers and length=0. RAM not cleared.
//  Reset mid-packet (load or send) abandons the packet; outputs hold reset values the next cycle.
//  Load: word accepted when load_valid_i && load_ready_o; written to RAM[wr_ptr], wr_ptr++.
//   Accept with load_last_i, or acceptance of word MAX_PKT_LEN (forced last) ->
//   len = wr_ptr+1 (AWIDTH+1 bits); state -> PREFETCH; load_ready_o=0 next cycle.
//  Source handshake: beat transfers when src_valid_o && src_ready_i.
//   While src_valid_o=1 and src_ready_i=0, data/sop/eop hold stable.
//   src_valid_o never drops before eop is transferred (except reset, or the gap feature).
//  FSM: LOAD -> PREFETCH (load_last accepted) -> SEND (first RAM word registered)
//   -> LOAD (eop beat transferred).
//  Latency: load_last accepted in cycle N -> src_valid_o=1 with word 0 in cycle N+2.
//  Throughput: 1 beat/clk while src_ready_i=1. RAM has 1-cycle read latency, so the reader
//   prefetches the next word; a 2-entry skid absorbs ready deassertion without loss or duplication.
//  src_startofpacket_o=1 only on beat 0. src_endofpacket_o=1 only on beat len-1.
//   len=1: sop and eop set on the same beat.
//  Counters: beat index AWIDTH+1 bits, no wrap inside a packet; pointers reset to 0 per packet.
//  load_ready_o=1 again in the cycle after the eop transfer; the next packet may load immediately.
//  busy_o=1 in PREFETCH and SEND.
//  load_valid_i while load_ready_o=0 is ignored; no data is stored.
// CONFIGURATION
//  SORT_PKT_TX_GAP_EN defined: after each transferred beat except eop, src_valid_o is forced 0
//   for exactly one cycle. Data is not lost, throughput is 1 beat/2 clk, and the sink sees bubbles.
//  SORT_PKT_TX_GAP_EN undefined: back-to-back beats as above.
// STRUCTURE
//  sort_pkg (shared with sort): tx_state_t enum {LOAD, PREFETCH, SEND};
//   localparam defaults DWIDTH/MAX_PKT_LEN; function addr_w(len) = $clog2(len).
//  Sub-module sort_pkt_tx_ram: simple dual-port RAM, 1 write port, 1 read port,
//   registered read (1-cycle latency), depth MAX_PKT_LEN, width DWIDTH.
//  Top holds the FSM, pointers, length/beat counters, skid buffer and output registers.
// TESTING
//  1. Load 5,3,9,1 (last on 1), ready=1 -> sop on 5, beats 5,3,9,1 in 4 consecutive clks,
//     eop on 1, valid 2 clks after last load.
//  2. Load 1 word 0xA5 with last -> single beat, sop=eop=1, data 0xA5; load_ready_o=1 next clk.
//  3. Load 8 words 0..7; ready toggles 1,0,0,1,0,1... -> output exactly 0..7 in order,
//     no duplicates, data/sop/eop stable while stalled.
//  4. Load MAX_PKT_LEN words, last never asserted -> packet of MAX_PKT_LEN beats, eop on word 1023.
//  5. srst_i pulsed mid-send after beat 2 of 6 -> next clk valid/sop/eop/busy=0, load_ready_o=1;
//     a new 3-word packet then sends correctly.
//  6. SORT_PKT_TX_GAP_EN defined, 4-word packet, ready=1 -> valid pattern 1,0,1,0,1,0,1; data intact.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort block and its packet transmitter.
package sort_pkg;

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      PREFETCH = 2'd1,
      SEND     = 2'd2
   } tx_state_t;

   localparam int DEF_DWIDTH      = 8;
   localparam int DEF_MAX_PKT_LEN = 1024;

   function automatic int addr_w(input int len);
      return $clog2(len);
   endfunction

endpackage

// File: rtl/sort_pkt_tx_ram.sv
// Simple dual-port packet RAM: one write port, one read port with a registered
// (1-cycle latency) read. Contents are never cleared.
module sort_pkt_tx_ram
   import sort_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int DEPTH  = DEF_MAX_PKT_LEN,
   parameter int AWIDTH = addr_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [AWIDTH-1:0] wr_addr_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AWIDTH-1:0] rd_addr_i,
   output logic [DWIDTH-1:0] rd_data_o
);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DWIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sort_pkt_tx.sv
// Avalon-ST packet transmitter: stores one packet from the load port, then replays it
// with sop/eop framing. Define SORT_PKT_TX_GAP_EN to insert a 1-cycle bubble after each non-eop beat.
module sort_pkt_tx
   import sort_pkg::*;
#(
   parameter int DWIDTH      = DEF_DWIDTH,
   parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] load_data_i,
   input  logic              load_valid_i,
   input  logic              load_last_i,
   output logic              load_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_startofpacket_o,
   output logic              src_endofpacket_o,
   output logic              src_valid_o,
   input  logic              src_ready_i,
   output logic              busy_o
);

   localparam int AWIDTH = addr_w(MAX_PKT_LEN);
   localparam int CWIDTH = AWIDTH + 1;
   localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(MAX_PKT_LEN - 1);

   tx_state_t         state_q, state_d;
   logic [CWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CWIDTH-1:0] len_q, len_d;
   logic [CWIDTH-1:0] rd_idx_q, rd_idx_d;
   logic              rd_vld_q, rd_vld_d;
   logic              fwd_q, fwd_d;
   logic [DWIDTH-1:0] fwd_data_q, fwd_data_d;
   logic              out_vld_q, out_vld_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic [DWIDTH-1:0] out_data_q, out_data_d;
   logic              sk_vld_q, sk_vld_d;
   logic              sk_sop_q, sk_sop_d;
   logic              sk_eop_q, sk_eop_d;
   logic [DWIDTH-1:0] sk_data_q, sk_data_d;
   logic              load_ready_q, load_ready_d;
   logic              busy_q, busy_d;

   logic              load_acc, load_done, pop, rd_issue, rd_en;
   logic              src_vld, push_sop, push_eop;
   logic [1:0]        buf_next;
   logic [DWIDTH-1:0] push_data, ram_rdata;

`ifdef SORT_PKT_TX_GAP_EN
   logic gap_q, gap_d;

   assign src_vld = out_vld_q & ~gap_q;
   assign gap_d   = pop & ~out_eop_q;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         gap_q <= 1'b0;
      end else begin
         gap_q <= gap_d;
      end
   end
`else
   assign src_vld = out_vld_q;
`endif

   always_comb begin
      load_acc  = load_valid_i & load_ready_q;
      load_done = load_acc & (load_last_i | (wr_ptr_q == LAST_IDX));
      pop       = src_vld & src_ready_i;
      // Words held after this cycle; a new read is only issued if its data will fit next cycle.
      buf_next  = 2'(out_vld_q) + 2'(sk_vld_q) + 2'(rd_vld_q) - 2'(pop);
      rd_issue  = (state_q != LOAD) & (rd_ptr_q < len_q) & (buf_next < 2'd2);
      rd_en     = rd_issue | load_done;
      // A one-word packet is read in the same cycle it is written, so bypass the RAM.
      push_data = fwd_q ? fwd_data_q : ram_rdata;
      push_sop  = (rd_idx_q == '0);
      push_eop  = (rd_idx_q == len_q - CWIDTH'(1));
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      len_d      = len_q;
      rd_idx_d   = rd_ptr_q;
      rd_vld_d   = 1'b0;
      fwd_d      = 1'b0;
      fwd_data_d = fwd_data_q;

      case (state_q)
         LOAD: begin
            if (load_acc) begin
               wr_ptr_d = wr_ptr_q + CWIDTH'(1);
            end
            // Word 0 is read while the last word is written, hiding the RAM latency.
            if (load_done) begin
               len_d      = wr_ptr_q + CWIDTH'(1);
               state_d    = PREFETCH;
               rd_vld_d   = 1'b1;
               rd_ptr_d   = CWIDTH'(1);
               fwd_d      = (wr_ptr_q == '0);
               fwd_data_d = load_data_i;
            end
         end
         PREFETCH, SEND: begin
            if (rd_issue) begin
               rd_vld_d = 1'b1;
               rd_ptr_d = rd_ptr_q + CWIDTH'(1);
            end
            if (state_q == PREFETCH) begin
               state_d = SEND;
            end else if (pop && out_eop_q) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               len_d    = '0;
            end
         end
         default: state_d = LOAD;
      endcase

      load_ready_d = (state_d == LOAD);
      busy_d       = (state_d != LOAD);
   end

   // Two-entry output queue: out_* is the presented beat, sk_* catches the word in flight on a stall.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_sop_d  = out_sop_q;
      out_eop_d  = out_eop_q;
      out_data_d = out_data_q;
      sk_vld_d   = sk_vld_q;
      sk_sop_d   = sk_sop_q;
      sk_eop_d   = sk_eop_q;
      sk_data_d  = sk_data_q;

      if (pop) begin
         out_vld_d = sk_vld_q;
         if (sk_vld_q) begin
            out_sop_d  = sk_sop_q;
            out_eop_d  = sk_eop_q;
            out_data_d = sk_data_q;
         end
         sk_vld_d = 1'b0;
      end

      if (rd_vld_q) begin
         if (!out_vld_d) begin
            out_vld_d  = 1'b1;
            out_sop_d  = push_sop;
            out_eop_d  = push_eop;
            out_data_d = push_data;
         end else begin
            sk_vld_d  = 1'b1;
            sk_sop_d  = push_sop;
            sk_eop_d  = push_eop;
            sk_data_d = push_data;
         end
      end

      if (!out_vld_d) begin
         out_sop_d = 1'b0;
         out_eop_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q      <= LOAD;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         len_q        <= '0;
         rd_vld_q     <= 1'b0;
         fwd_q        <= 1'b0;
         out_vld_q    <= 1'b0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_data_q   <= '0;
         sk_vld_q     <= 1'b0;
         load_ready_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         len_q        <= len_d;
         rd_vld_q     <= rd_vld_d;
         fwd_q        <= fwd_d;
         out_vld_q    <= out_vld_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         out_data_q   <= out_data_d;
         sk_vld_q     <= sk_vld_d;
         load_ready_q <= load_ready_d;
         busy_q       <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      rd_idx_q   <= rd_idx_d;
      fwd_data_q <= fwd_data_d;
      sk_sop_q   <= sk_sop_d;
      sk_eop_q   <= sk_eop_d;
      sk_data_q  <= sk_data_d;
   end

   sort_pkt_tx_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (MAX_PKT_LEN),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (load_acc),
      .wr_addr_i (wr_ptr_q[AWIDTH-1:0]),
      .wr_data_i (load_data_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q[AWIDTH-1:0]),
      .rd_data_o (ram_rdata)
   );

   assign load_ready_o        = load_ready_q;
   assign src_data_o          = out_data_q;
   assign src_startofpacket_o = out_sop_q;
   assign src_endofpacket_o   = out_eop_q;
   assign src_valid_o         = src_vld;
   assign busy_o              = busy_q;

endmodule
